// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART transmit path: byte width, the bit-rate
//   divisor for a 50 MHz clock at 9600 baud, and the state type of the
//   transmit arbiter FSM.
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int BYTE_W   = 8;
   localparam int CLK_HZ   = 50_000_000;
   localparam int BAUD     = 9600;
   // 50e6 / 9600 = 5208.33, truncated
   localparam int BAUD_DIV = 5208;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_BUSY,
      WAIT_DONE,
      GAP
   } arb_state_t;

endpackage : uart_pkg

// File: rtl/uart_rr_pick.sv
// -----------------------------------------------------------------------------
// uart_rr_pick
//   Combinational round-robin selector. The scan starts at (last+1) mod N_REQ
//   and wraps, so the requester granted most recently has the lowest priority.
//
// Ports
//   req     in  N_REQ  request vector, bit i = requester i wants service
//   last    in  3      index of the previously granted requester
//   winner  out 3      index of the selected requester (0 when any is low)
//   any     out 1      at least one request is present
// -----------------------------------------------------------------------------
module uart_rr_pick #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0] req,
   input  logic [2:0]       last,
   output logic [2:0]       winner,
   output logic             any
);

   logic [7:0] req_x;
   logic [2:0] idx;

   always_comb begin
      req_x  = 8'(req);
      winner = '0;
      any    = 1'b0;
      idx    = '0;
      // First hit in scan order wins; later hits are masked by 'any'.
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         idx = 3'((32'(last) + k) % N_REQ);
         if (!any && req_x[idx]) begin
            any    = 1'b1;
            winner = idx;
         end
      end
   end

endmodule : uart_rr_pick

// File: rtl/uart_tx_arb.sv
// -----------------------------------------------------------------------------
// uart_tx_arb
//   Round-robin arbiter that feeds bytes from N_REQ requesters into a single
//   shared UART transmitter. A byte is accepted only while idle, then handed
//   to the transmitter with a one-cycle tx_start, after which the arbiter
//   waits for the frame to start and finish, inserts an optional idle gap and
//   returns to idle. A transmitter that never raises tx_busy is flagged with
//   tx_err and the frame is dropped.
//
// Ports
//   clk        in  1        system clock, rising edge
//   rst_n      in  1        asynchronous active-low reset
//   req_valid  in  N_REQ    requester i holds a byte
//   req_data   in  8*N_REQ  byte of requester i at [8i+7:8i]
//   req_ready  out N_REQ    one-hot, one-cycle accept pulse
//   tx_data    out 8        byte presented to the transmitter
//   tx_start   out 1        one-cycle frame start pulse
//   tx_busy    in  1        transmitter frame in progress
//   grant_id   out 3        index of the most recently accepted requester
//   tx_err     out 1        one-cycle pulse when tx_busy fails to rise
// -----------------------------------------------------------------------------
module uart_tx_arb
   import uart_pkg::*;
#(
   parameter int N_REQ        = 4,
   parameter int BUSY_TIMEOUT = 4,
   parameter int GAP_CYCLES   = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [BYTE_W*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]        req_ready,
   output logic [BYTE_W-1:0]       tx_data,
   output logic                    tx_start,
   input  logic                    tx_busy,
   output logic [2:0]              grant_id,
   output logic                    tx_err
);

   localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   arb_state_t        state,     state_d;
   logic [2:0]        last,      last_d;
   logic [2:0]        to_cnt,    to_cnt_d;
   logic [GAP_W-1:0]  gap_cnt,   gap_cnt_d;
   logic [BYTE_W-1:0] tx_data_d;
   logic [N_REQ-1:0]  req_ready_d;
   logic [2:0]        grant_d;
   logic              tx_start_d;
   logic              tx_err_d;

   logic [2:0]        pick_win;
   logic              pick_any;
   logic [BYTE_W-1:0] win_byte;
   logic [N_REQ-1:0]  win_onehot;

   uart_rr_pick #(
      .N_REQ (N_REQ)
   ) u_pick (
      .req    (req_valid),
      .last   (last),
      .winner (pick_win),
      .any    (pick_any)
   );

   // Byte and one-hot of the current round-robin winner.
   always_comb begin
      win_byte   = '0;
      win_onehot = N_REQ'(1'b1) << pick_win;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (pick_win == 3'(k)) begin
            win_byte = req_data[BYTE_W*k +: BYTE_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         last      <= 3'(N_REQ - 1);
         to_cnt    <= '0;
         gap_cnt   <= '0;
         tx_data   <= '0;
         req_ready <= '0;
         grant_id  <= '0;
         tx_start  <= 1'b0;
         tx_err    <= 1'b0;
      end else begin
         state     <= state_d;
         last      <= last_d;
         to_cnt    <= to_cnt_d;
         gap_cnt   <= gap_cnt_d;
         tx_data   <= tx_data_d;
         req_ready <= req_ready_d;
         grant_id  <= grant_d;
         tx_start  <= tx_start_d;
         tx_err    <= tx_err_d;
      end
   end

   always_comb begin
      state_d     = state;
      last_d      = last;
      to_cnt_d    = to_cnt;
      gap_cnt_d   = gap_cnt;
      tx_data_d   = tx_data;
      grant_d     = grant_id;
      req_ready_d = '0;
      tx_start_d  = 1'b0;
      tx_err_d    = 1'b0;

      unique case (state)
         IDLE: begin
            // tx_busy is deliberately not looked at here; ISSUE waits for it.
            if (pick_any) begin
               tx_data_d   = win_byte;
               req_ready_d = win_onehot;
               grant_d     = pick_win;
               last_d      = pick_win;
               state_d     = ISSUE;
            end
         end

         ISSUE: begin
            if (!tx_busy) begin
               tx_start_d = 1'b1;
               to_cnt_d   = '0;
               state_d    = WAIT_BUSY;
            end
         end

         WAIT_BUSY: begin
            // to_cnt counts completed waiting cycles; the timeout fires on the
            // edge that ends the BUSY_TIMEOUT-th one, which puts tx_err
            // BUSY_TIMEOUT cycles after tx_start.
            if (tx_busy) begin
               state_d = WAIT_DONE;
            end else if ((4'(to_cnt) + 4'd1) == 4'(BUSY_TIMEOUT)) begin
               tx_err_d  = 1'b1;
               gap_cnt_d = GAP_W'(GAP_CYCLES);
               state_d   = GAP;
            end else begin
               to_cnt_d = to_cnt + 3'd1;
            end
         end

         WAIT_DONE: begin
            if (!tx_busy) begin
               gap_cnt_d = GAP_W'(GAP_CYCLES);
               state_d   = GAP;
            end
         end

         GAP: begin
            if (gap_cnt == '0) begin
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt - 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule : uart_tx_arb

// File: tb/tb_uart_tx_arb.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arb
//   Self-checking bench for uart_tx_arb. The bench plays both the requesters
//   and the transmitter. Each frame is described at transaction level (who
//   requests, how long tx_busy is held at acceptance, when the transmitter
//   starts and how long it runs); the expected cycle of every output event is
//   derived from that description with plain arithmetic and every cycle of the
//   frame is compared.
// -----------------------------------------------------------------------------
module tb_uart_tx_arb;

   localparam int NR = 4;
   localparam int BT = 4;
   localparam int GP = 5;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NR-1:0]   req_valid;
   logic [8*NR-1:0] req_data;
   logic [NR-1:0]   req_ready;
   logic [7:0]      tx_data;
   logic            tx_start;
   logic            tx_busy;
   logic [2:0]      grant_id;
   logic            tx_err;

   uart_tx_arb #(
      .N_REQ        (NR),
      .BUSY_TIMEOUT (BT),
      .GAP_CYCLES   (GP)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .tx_data   (tx_data),
      .tx_start  (tx_start),
      .tx_busy   (tx_busy),
      .grant_id  (grant_id),
      .tx_err    (tx_err)
   );

   always #10 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int last_m;          // reference model: last granted requester

   typedef struct {
      logic [NR-1:0]   v;
      logic [8*NR-1:0] d;
      int              h;    // cycles tx_busy is held high from acceptance
      int              dly;  // cycles from tx_start to tx_busy rising
      int              len;  // cycles tx_busy stays high
      int              g;    // expected grant
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic int pick(input logic [NR-1:0] v);
      for (int i = 1; i <= NR; i++) begin
         if (v[(last_m + i) % NR]) return (last_m + i) % NR;
      end
      return 0;
   endfunction

   function automatic logic [8*NR-1:0] rand_d();
      logic [8*NR-1:0] r;
      for (int i = 0; i < NR; i++) r[8*i +: 8] = 8'($urandom);
      return r;
   endfunction

   function automatic logic [NR-1:0] rand_v();
      return NR'($urandom_range(1, (1 << NR) - 1));
   endfunction

   // Called in the cycle before the expected acceptance edge (DUT idle).
   // Returns in the cycle before the next possible acceptance, with nv/nd
   // already driven.
   //   a : cycle req_ready is seen
   //   s : cycle tx_start is seen (edge after the first tx_busy-low cycle)
   //   e : cycle tx_err is seen when the transmitter never starts
   //   r : next acceptance cycle = busy-low seen, GP+1 gap cycles, 1 idle
   task automatic frame(input logic [NR-1:0] v, input logic [8*NR-1:0] d,
                        input int h, input int dly, input int len, input int exp_w,
                        input logic [NR-1:0] nv, input logic [8*NR-1:0] nd);
      int         a, s, e, r;
      bit         tmo;
      logic [7:0] b;
      req_valid = v;
      req_data  = d;
      tx_busy   = (h > 0);
      b   = d[8*exp_w +: 8];
      a   = cyc + 1;
      s   = a + h + 1;
      tmo = (dly >= BT);
      e   = s + BT;
      r   = tmo ? (s + BT + GP + 2) : (s + dly + len + GP + 3);
      for (int c = a; c < r; c++) begin
         step();
         if (c == a) chk("req_ready_accept", int'(req_ready), 1 << exp_w);
         else        chk("req_ready_quiet", int'(req_ready), 0);
         chk("grant_id", int'(grant_id), exp_w);
         chk("tx_data", int'(tx_data), int'(b));
         chk("tx_start", int'(tx_start), int'(c == s));
         chk("tx_err", int'(tx_err), int'(tmo && c == e));
         if (c < a + h)                                     tx_busy = 1'b1;
         else if (!tmo && c >= s + dly && c < s + dly + len) tx_busy = 1'b1;
         else                                               tx_busy = 1'b0;
         if (c == r - 1) begin
            req_valid = nv;
            req_data  = nd;
         end else begin
            // anything driven outside idle must be ignored
            req_valid = NR'($urandom);
            req_data  = rand_d();
         end
      end
      last_m = exp_w;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
      $fatal(1);
   end

   initial begin
      logic [NR-1:0]   nv, cv;
      logic [8*NR-1:0] nd, cd;

      rst_n     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      tx_busy   = 1'b0;
      last_m    = NR - 1;

      tbl[0] = '{4'b1111, 32'h1312_1110, 0, 1, 2, 0};
      tbl[1] = '{4'b1111, 32'h1312_1110, 0, 1, 2, 1};
      tbl[2] = '{4'b1111, 32'h1312_1110, 0, 1, 2, 2};
      tbl[3] = '{4'b1111, 32'h1312_1110, 0, 1, 2, 3};
      tbl[4] = '{4'b1111, 32'h1312_1110, 0, 1, 2, 0};
      tbl[5] = '{4'b0100, 32'h11A5_2233, 0, 3, 4, 2};
      tbl[6] = '{4'b0010, 32'h4455_3C66, 10, 1, 3, 1};
      tbl[7] = '{4'b1000, 32'h5A00_0000, 0, 9, 1, 3};
      tbl[8] = '{4'b0011, 32'h0000_7788, 0, 0, 1, 0};
      tbl[9] = '{4'b0011, 32'h0000_7788, 2, 2, 5, 1};

      step();
      step();
      chk("rst_req_ready", int'(req_ready), 0);
      chk("rst_tx_start", int'(tx_start), 0);
      chk("rst_tx_err", int'(tx_err), 0);
      chk("rst_tx_data", int'(tx_data), 0);
      chk("rst_grant_id", int'(grant_id), 0);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         if (i < 9) begin
            nv = tbl[i+1].v;
            nd = tbl[i+1].d;
         end else begin
            nv = '0;
            nd = '0;
         end
         frame(tbl[i].v, tbl[i].d, tbl[i].h, tbl[i].dly, tbl[i].len, tbl[i].g, nv, nd);
      end

      // nothing requested: stays idle
      for (int i = 0; i < 4; i++) begin
         step();
         chk("idle_req_ready", int'(req_ready), 0);
         chk("idle_tx_start", int'(tx_start), 0);
      end

      // reset while the transmitter is mid-frame
      req_valid = 4'b0100;
      req_data  = 32'h00C3_0000;
      step();
      chk("rst_seq_accept", int'(req_ready), 4);
      step();
      chk("rst_seq_start", int'(tx_start), 1);
      tx_busy = 1'b1;
      step();
      step();
      rst_n = 1'b0;
      #1;
      chk("async_rst_req_ready", int'(req_ready), 0);
      chk("async_rst_tx_start", int'(tx_start), 0);
      chk("async_rst_tx_err", int'(tx_err), 0);
      chk("async_rst_tx_data", int'(tx_data), 0);
      chk("async_rst_grant_id", int'(grant_id), 0);
      tx_busy = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("in_rst_req_ready", int'(req_ready), 0);
         chk("in_rst_tx_start", int'(tx_start), 0);
      end
      rst_n  = 1'b1;
      last_m = NR - 1;
      cv = rand_v();
      cd = rand_d();
      frame(4'b1001, 32'h9988_7766, 0, 1, 2, 0, cv, cd);

      // randomized frames against the reference model
      for (int i = 0; i < 40; i++) begin
         int h, dly, len;
         nv  = rand_v();
         nd  = rand_d();
         h   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
         dly = $urandom_range(0, 5);
         len = $urandom_range(1, 4);
         frame(cv, cd, h, dly, len, pick(cv), nv, nd);
         cv = nv;
         cd = nd;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_uart_tx_arb

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of byte requesters (2..8).
REQ-002 SHALL have parameter BUSY_TIMEOUT, default 4, maximum cycles from tx_start to tx_busy high.
REQ-003 SHALL have parameter GAP_CYCLES, default 0, idle cycles inserted between frames.
REQ-004 SHALL have port clk  in  1  single system clock (50 MHz), all logic on posedge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  in  N_REQ  bit i high = requester i holds a byte.
REQ-007 SHALL have port req_data  in  8*N_REQ  byte of requester i at [8i+7:8i].
REQ-008 SHALL have port req_ready  out  N_REQ  one-hot one-cycle accept pulse.
REQ-009 SHALL have port tx_data  out  8  byte presented to the shared UART transmitter.
REQ-010 SHALL have port tx_start  out  1  one-cycle frame start pulse to the transmitter.
REQ-011 SHALL have port tx_busy  in  1  transmitter frame in progress.
REQ-012 SHALL have port grant_id  out  3  index of the most recently accepted requester.
REQ-013 SHALL have port tx_err  out  1  one-cycle pulse on busy-timeout.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP.
REQ-015 IDLE: any req_valid sampled high -> winner chosen round-robin, starting at (last+1) mod N_REQ; on that edge tx_data <= winner byte, req_ready <= onehot(winner), grant_id <= winner, last <= winner, state -> ISSUE.
REQ-016 req_ready SHALL be high exactly one cycle (first ISSUE cycle), then zero until the next acceptance.
REQ-017 req_valid/req_data SHALL be sampled only in IDLE; changes in other states are ignored; the latched byte is never altered until the next acceptance.
REQ-018 ISSUE: tx_busy low -> tx_start high for the next single cycle, state -> WAIT_BUSY; tx_busy high -> remain in ISSUE.
REQ-019 WAIT_BUSY: 3-bit timeout counter cleared on entry, incremented each cycle; tx_busy high -> WAIT_DONE; counter == BUSY_TIMEOUT with tx_busy low -> tx_err pulse one cycle, state -> GAP.
REQ-020 WAIT_DONE: tx_busy low -> GAP, gap counter loaded with GAP_CYCLES.
REQ-021 GAP: decrement each cycle; counter zero -> IDLE (GAP_CYCLES=0 gives one GAP cycle).
REQ-022 Minimum latency req_valid -> tx_start SHALL be 2 cycles with tx_busy low.
REQ-023 Round-robin pointer SHALL wrap N_REQ-1 -> 0; a requester holding valid continuously SHALL wait at most N_REQ-1 frames.
REQ-024 Equal-priority ties are impossible: the scan order from last+1 is strict.
REQ-025 tx_busy high while in IDLE SHALL not block acceptance; ISSUE waits for it.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, req_ready 0, tx_start 0, tx_err 0, tx_data 8'h00, grant_id 0, counters 0, last = N_REQ-1 (requester 0 first).
REQ-027 Reset mid-frame SHALL abandon the byte without tx_start or req_ready; first post-reset acceptance occurs on the first edge after rst_n rises.

Structure
REQ-028 Shared package uart_pkg SHALL hold the FSM state type, byte width 8, and the 50 MHz / 9600 baud divisor 5208.
REQ-029 Round-robin selection SHALL be one combinational sub-module uart_rr_pick (inputs req vector, last index; outputs winner index, any).

Verification
REQ-030 Single: req_valid=4'b0100, data byte2=8'hA5, tx_busy pulses high 3 cycles after tx_start -> req_ready=4'b0100 one cycle, tx_start 2 cycles after valid, tx_data=8'hA5, grant_id=2.
REQ-031 Fairness: req_valid=4'b1111 held, bytes 8'h10..8'h13 -> grant order 0,1,2,3,0 across five frames.
REQ-032 Backpressure: tx_busy held high at acceptance for 10 cycles -> tx_start issued first cycle after tx_busy falls, exactly once.
REQ-033 Timeout: tx_busy never rises -> tx_err pulse at cycle BUSY_TIMEOUT=4 after tx_start, FSM returns IDLE, next request served.
REQ-034 Gap: GAP_CYCLES=5, two requesters -> 6 cycles between tx_busy falling and next req_ready.
REQ-035 Reset: rst_n low during WAIT_DONE -> outputs at reset values same cycle; after release req_valid=4'b1001 grants requester 0.
